// File: rtl/hazard_control_unit_pkg.sv
// hazard_control_unit_pkg: shared state encoding and constants for the hazard controller
package hazard_control_unit_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        ERROR = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-side hazard inputs and stage control outputs
interface hazard_control_unit_if #(parameter int CNT_W = 16);

    logic [4:0]       IF_ID_rs;
    logic [4:0]       IF_ID_rt;
    logic             IF_ID_usesRt;
    logic             ID_EX_memRead;
    logic [4:0]       ID_EX_rt;
    logic             EX_branchTaken;
    logic             MEM_memBusy;
    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             ID_EX_write;
    logic             EX_MEM_write;
    logic             MEM_WB_bubble;
    logic             memTimeout;
    logic [CNT_W-1:0] stallCycles;
    logic [CNT_W-1:0] flushCount;

    modport master (
        output IF_ID_rs, IF_ID_rt, IF_ID_usesRt, ID_EX_memRead, ID_EX_rt,
               EX_branchTaken, MEM_memBusy,
        input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_write,
               EX_MEM_write, MEM_WB_bubble, memTimeout, stallCycles, flushCount
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, IF_ID_usesRt, ID_EX_memRead, ID_EX_rt,
               EX_branchTaken, MEM_memBusy,
        output PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_write,
               EX_MEM_write, MEM_WB_bubble, memTimeout, stallCycles, flushCount
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// sat_counter: up counter that sticks at all-ones, with synchronous clear
module sat_counter #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use stalls, taken-branch squash and memory-busy freeze for a 5-stage pipeline
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    hazard_control_unit_if.slave bus
);

    localparam int BW = $clog2(TIMEOUT + 1);

    state_t        state, state_next;
    logic [BW-1:0] busy_cnt;
    logic          load_use, active, freeze, branch, stall;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_next;
    end

    // while rst_n is low every control output falls back to the free-running defaults
    always_comb begin
        load_use = bus.ID_EX_memRead && bus.ID_EX_rt != REG_ZERO &&
                   (bus.ID_EX_rt == bus.IF_ID_rs || (bus.IF_ID_usesRt && bus.ID_EX_rt == bus.IF_ID_rt));
        active = rst_n && state != ERROR;
        freeze = rst_n && (state == ERROR || bus.MEM_memBusy);
        branch = active && !bus.MEM_memBusy && bus.EX_branchTaken;
        stall  = active && !bus.MEM_memBusy && !bus.EX_branchTaken && load_use;
        bus.PC_write      = !freeze && !stall;
        bus.IF_ID_write   = !freeze && !stall;
        bus.IF_ID_flush   = branch;
        bus.ID_EX_bubble  = branch || stall;
        bus.ID_EX_write   = !freeze;
        bus.EX_MEM_write  = !freeze;
        bus.MEM_WB_bubble = freeze;
        bus.memTimeout    = state == ERROR;
        state_next = state == ERROR ? ERROR :
                     !bus.MEM_memBusy ? RUN :
                     (state == HOLD && busy_cnt == BW'(TIMEOUT - 1)) ? ERROR : HOLD;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (active && (bus.MEM_memBusy || stall)),
        .count (bus.stallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (branch),
        .count (bus.flushCount)
    );

    sat_counter #(.W(BW)) u_busy_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!bus.MEM_memBusy),
        .inc   (active && bus.MEM_memBusy),
        .count (busy_cnt)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed and random stimulus checked against a cycle-level rule model
module tb_hazard_control_unit;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, ID_EX_write, EX_MEM_write, MEM_WB_bubble}
    localparam logic [6:0] O_DEF = 7'b1100110;
    localparam logic [6:0] O_FRZ = 7'b0000001;
    localparam logic [6:0] O_FLS = 7'b1111110;
    localparam logic [6:0] O_STL = 7'b0001110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    int   m_run = 0;
    bit   m_err = 0;

    hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

    hazard_control_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {bus.PC_write, bus.IF_ID_write, bus.IF_ID_flush, bus.ID_EX_bubble,
                bus.ID_EX_write, bus.EX_MEM_write, bus.MEM_WB_bubble};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int rs, input int rt, input bit ur, input bit mr,
                         input int ert, input bit br, input bit busy);
        bus.IF_ID_rs       = 5'(rs);
        bus.IF_ID_rt       = 5'(rt);
        bus.IF_ID_usesRt   = ur;
        bus.ID_EX_memRead  = mr;
        bus.ID_EX_rt       = 5'(ert);
        bus.EX_branchTaken = br;
        bus.MEM_memBusy    = busy;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_stall"}, 32'(bus.stallCycles), 32'(m_stall));
        chk({tag, "_flush"}, 32'(bus.flushCount), 32'(m_flush));
        chk({tag, "_tmo"}, 32'(bus.memTimeout), 32'(m_err));
    endtask

    // one clock of normal operation: outputs checked mid-cycle, registers after the edge
    task automatic step(input string tag, input int rs, input int rt, input bit ur, input bit mr,
                        input int ert, input bit br, input bit busy);
        logic [6:0] exp;
        bit lu;
        @(negedge clk);
        drive(rs, rt, ur, mr, ert, br, busy);
        #1;
        lu = mr && ert != 0 && (ert == rs || (ur && ert == rt));
        if (m_err) exp = O_FRZ;
        else if (busy) begin
            exp = O_FRZ;
            m_stall = m_stall < CNT_MAX ? m_stall + 1 : m_stall;
            m_run++;
            if (m_run >= TIMEOUT) m_err = 1;
        end else begin
            m_run = 0;
            if (br) begin
                exp = O_FLS;
                m_flush = m_flush < CNT_MAX ? m_flush + 1 : m_flush;
            end else if (lu) begin
                exp = O_STL;
                m_stall = m_stall < CNT_MAX ? m_stall + 1 : m_stall;
            end else exp = O_DEF;
        end
        chk({tag, "_outs"}, 32'(outs()), 32'(exp));
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset(input string tag, input bit busy);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, busy);
        #1;
        chk({tag, "_outs"}, 32'(outs()), 32'(O_DEF));
        @(posedge clk);
        #1;
        m_stall = 0;
        m_flush = 0;
        m_run = 0;
        m_err = 0;
        check_regs(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset("reset", 1'b0);
        step("loaduse_rs", 3, 7, 1, 1, 3, 0, 0);
        step("after_lu", 3, 7, 1, 0, 0, 0, 0);
        step("lu_zero_reg", 0, 0, 1, 1, 0, 0, 0);
        step("lu_rt_unused", 1, 5, 0, 1, 5, 0, 0);
        step("lu_rt_used", 1, 5, 1, 1, 5, 0, 0);
        step("br_and_lu", 3, 2, 1, 1, 3, 1, 0);
        for (int i = 0; i < 3; i++) step("busy3", 3, 2, 1, 1, 3, 0, 1);
        step("busy_release", 0, 0, 0, 0, 0, 0, 0);
        step("br_in_hold0", 1, 1, 0, 0, 0, 1, 1);
        step("br_in_hold1", 1, 1, 0, 0, 0, 1, 1);
        step("br_release", 1, 1, 0, 0, 0, 1, 0);
        step("lu_release_pre", 0, 0, 0, 0, 0, 0, 1);
        step("lu_release", 4, 0, 0, 1, 4, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step("busy63", 0, 0, 0, 0, 0, 0, 1);
        step("no_timeout", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step("busy64", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step("error_hold", 2, 2, 1, 1, 2, i[0], 0);
        do_reset("reset_err", 1'b0);
        for (int i = 0; i < 5; i++) step("hold_pre_rst", 6, 0, 0, 1, 6, 0, 1);
        do_reset("reset_hold", 1'b1);
        step("post_rst", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            if (i % 200 == 199) do_reset("rand_rst", 1'($urandom_range(0, 1)));
            step("rand", $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0);
        end
        do_reset("reset_sat", 1'b0);
        for (int i = 0; i < CNT_MAX + 4; i++) step("sat", 9, 0, 0, 1, 9, 0, 0);
        chk("sat_final", 32'(bus.stallCycles), 32'(CNT_MAX));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and stall controller for the 5-stage MIPS core; the producer-side complement of operand forwarding. It detects load-use hazards that forwarding cannot cover, squashes wrong-path instructions on taken branches, and freezes the pipeline while data memory is busy. It drives the write enables, flushes and bubbles of PC, IF/ID, ID/EX and EX/MEM, and keeps saturating stall/flush performance counters plus a sticky memory-timeout error.

## Interface
- CNT_W, 16, width of performance counters
- TIMEOUT, 64, max consecutive busy cycles before error (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- IF_ID_rs  in  5  source rs of instruction in ID
- IF_ID_rt  in  5  source rt of instruction in ID
- IF_ID_usesRt  in  1  ID instruction reads rt as operand
- ID_EX_memRead  in  1  instruction in EX is a load
- ID_EX_rt  in  5  load destination in EX
- EX_branchTaken  in  1  branch in EX resolved taken
- MEM_memBusy  in  1  data memory not ready this cycle
- PC_write  out  1  PC update enable
- IF_ID_write  out  1  IF/ID load enable
- IF_ID_flush  out  1  IF/ID cleared to NOP
- ID_EX_bubble  out  1  ID/EX control zeroed (NOP)
- ID_EX_write  out  1  ID/EX load enable
- EX_MEM_write  out  1  EX/MEM load enable
- MEM_WB_bubble  out  1  MEM/WB control zeroed
- memTimeout  out  1  sticky error
- stallCycles  out  CNT_W  load-use + hold cycles, saturating
- flushCount  out  CNT_W  taken-branch flushes, saturating

## Operation
- FSM states RUN, HOLD, ERROR; reset → RUN.
- loadUse = ID_EX_memRead && ID_EX_rt≠0 && (ID_EX_rt==IF_ID_rs || (IF_ID_usesRt && ID_EX_rt==IF_ID_rt)).
- Default outputs (RUN, no event): all *_write=1, flush/bubble=0.
- Priority: ERROR > memBusy > branch > loadUse.
- RUN, MEM_memBusy=1: freeze — PC_write, IF_ID_write, ID_EX_write, EX_MEM_write=0, MEM_WB_bubble=1; next HOLD, busy counter=1.
- RUN, EX_branchTaken=1 (no busy): IF_ID_flush=1, ID_EX_bubble=1, PC_write=1; flushCount+1. loadUse ignored this cycle.
- RUN, loadUse (no busy, no branch): PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stallCycles+1. Single bubble; condition self-clears next cycle as load advances.
- HOLD: freeze outputs as above every cycle MEM_memBusy=1; busy counter+1, stallCycles+1. MEM_memBusy=0 → same cycle outputs evaluated as RUN (branch/loadUse honoured), next RUN, busy counter cleared.
- HOLD, busy counter reaches TIMEOUT with busy still 1 → next ERROR, memTimeout=1.
- ERROR: full freeze permanently; memTimeout=1; counters stop; exit only via reset.
- Counters saturate at 2^CNT_W−1; no wrap.
- branch in EX during HOLD is frozen, not lost; acted on at release.

## Timing
- Hazard/flush/freeze outputs combinational from state + inputs (same-cycle effect); state, counters, memTimeout registered.
- Reset (rst_n=0 at edge): state RUN, counters 0, memTimeout 0, busy counter 0. Outputs reflect RUN defaults in reset cycle (mid-stall reset fully abandons stall).
- Load-use stall latency: exactly 1 bubble cycle. Branch penalty: 2 squashed instructions, 0 extra cycles.
- Freeze begins in first busy cycle; ERROR entered on edge after TIMEOUT-th consecutive busy cycle.
- Counter updates visible the cycle after the event.

## Structure
- Shared package: state encoding enum (RUN, HOLD, ERROR), REG_ZERO constant 5'd0.
- One sub-module natural: sat_counter (parameterized width, inc, rst_n), instantiated for stallCycles, flushCount and busy counter.

## Test plan
- lw $3 in EX (ID_EX_memRead=1, rt=3), ID rs=3 → one cycle PC_write=0, IF_ID_write=0, ID_EX_bubble=1; stallCycles=1 next cycle; next cycle defaults.
- Load rt=0 with ID rs=0, or IF_ID_usesRt=0 and rt match only → no stall.
- EX_branchTaken=1 with loadUse simultaneously → IF_ID_flush=1, ID_EX_bubble=1, PC_write=1; flushCount=1, stallCycles=0.
- MEM_memBusy=1 for 3 cycles → all writes 0, MEM_WB_bubble=1 for 3 cycles, stallCycles=3, then RUN; busy for TIMEOUT=64 cycles → memTimeout=1, freeze persists after busy drops until rst_n=0.
- Force 65535 loadUse events → stallCycles holds 65535; rst_n low mid-HOLD → RUN, counters 0 next cycle.
